// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid_if
//  Description : Handshake, payload, clear and status bundle for one
//                pipeline-stage register (upstream, downstream and control).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
   parameter int DATA_W = 136,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic              req;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  drop_cnt;

   // Side that drives the stage: upstream producer, downstream consumer, control.
   modport master (
      output in_valid, in_data, out_ready, flush, req,
      input  in_ready, out_valid, out_data, occupancy, drop_cnt
   );

   // The stage register itself.
   modport slave (
      input  in_valid, in_data, out_ready, flush, req,
      output in_ready, out_valid, out_data, occupancy, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Handshaked pipeline-stage register with optional 2-entry
//                skid buffer, flush/exception clear to a bubble and a
//                saturating count of discarded instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
   parameter int                DATA_W  = 136,
   parameter logic [DATA_W-1:0] RST_VAL = '0,
   parameter int                SKID_EN = 1,
   parameter int                CNT_W   = 16
) (
   input  wire logic         clk,
   input  wire logic         reset_n,
   pipe_stage_skid_if.slave  bus
);

   // Occupancy-coded states: the encoding equals the number of valid entries.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   localparam logic [CNT_W:0] c_cnt_max = {1'b0, {CNT_W{1'b1}}};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_m_data;
   logic [DATA_W-1:0] w_s_data;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic              w_m_valid;
   logic              w_s_valid;
   logic              w_in_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_clr;
   logic              w_m_load_in;
   logic              w_m_load_s;
   logic              w_m_clear;
   logic              w_s_load_in;
   logic              w_s_clear;
   logic [1:0]        w_drop_inc;
   logic [CNT_W:0]    w_drop_sum;

   assign w_m_valid = (r_state != ST_EMPTY);
   assign w_s_valid = (r_state == ST_TWO);
   assign w_push    = bus.in_valid & w_in_ready;
   assign w_pop     = w_m_valid & bus.out_ready;
   assign w_clr     = bus.flush | bus.req;

   // State register; reset lands in EMPTY so in_ready is high during reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-entry load/clear strobes; a clear overrides push/pop.
   always_comb begin
      w_state_nxt = r_state;
      w_m_load_in = 1'b0;
      w_m_load_s  = 1'b0;
      w_m_clear   = 1'b0;
      w_s_load_in = 1'b0;
      w_s_clear   = 1'b0;
      if (w_clr) begin
         w_state_nxt = ST_EMPTY;
         w_m_clear   = 1'b1;
         w_s_clear   = 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_nxt = ST_ONE;
                  w_m_load_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && w_pop) begin
                  w_m_load_in = 1'b1;
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
                  w_m_clear   = 1'b1;
               end else if (w_push && (SKID_EN != 0)) begin
                  w_state_nxt = ST_TWO;
                  w_s_load_in = 1'b1;
               end
            end
            ST_TWO: begin
               if (w_pop) begin
                  w_state_nxt = ST_ONE;
                  w_m_load_s  = 1'b1;
                  w_s_clear   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
               w_m_clear   = 1'b1;
               w_s_clear   = 1'b1;
            end
         endcase
      end
   end

   // Main entry payload; an emptied entry reloads RST_VAL so bubbles never carry stale fields.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_m_data <= RST_VAL;
      end else if (w_m_clear) begin
         r_m_data <= RST_VAL;
      end else if (w_m_load_in) begin
         r_m_data <= bus.in_data;
      end else if (w_m_load_s) begin
         r_m_data <= w_s_data;
      end
   end

   generate
      if (SKID_EN != 0) begin : g_skid
         logic [DATA_W-1:0] r_s_data;

         // Skid entry payload, only written when downstream stalls with M full.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_s_data <= RST_VAL;
            end else if (w_s_clear) begin
               r_s_data <= RST_VAL;
            end else if (w_s_load_in) begin
               r_s_data <= bus.in_data;
            end
         end

         assign w_s_data   = r_s_data;
         // Depends only on registered state: no path from out_ready to in_ready.
         assign w_in_ready = (r_state != ST_TWO);
      end else begin : g_noskid
         assign w_s_data   = RST_VAL;
         // Single entry: accept when empty or when the held item leaves this cycle.
         assign w_in_ready = (r_state == ST_EMPTY) | bus.out_ready;
      end
   endgenerate

   // Discards on a clear: entries not popped this cycle plus any same-cycle push.
   assign w_drop_inc = 2'(w_m_valid & ~w_pop) + 2'(w_s_valid) + 2'(w_push);
   assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop_inc);

   // Saturating discard counter, stuck at all-ones once reached.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop_cnt <= '0;
      end else if (w_clr) begin
         r_drop_cnt <= (w_drop_sum > c_cnt_max) ? c_cnt_max[CNT_W-1:0]
                                                : w_drop_sum[CNT_W-1:0];
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_m_valid;
   assign bus.out_data  = r_m_data;
   assign bus.occupancy = r_state;
   assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Self-checking bench for pipe_stage_skid: directed vector
//                table, hand-written corner sequences (saturation, async
//                reset, no-skid ready) and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

   localparam int DW = 136;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) m_if ();
   pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(2))  s_if ();
   pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) n_if ();

   pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1), .CNT_W(16)) u_main (
      .clk(clk), .reset_n(reset_n), .bus(m_if));
   pipe_stage_skid #(.DATA_W(DW), .SKID_EN(1), .CNT_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .bus(s_if));
   pipe_stage_skid #(.DATA_W(DW), .SKID_EN(0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset_n(reset_n), .bus(n_if));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        rq;
      logic        ev;
      logic [31:0] ed;
      logic [1:0]  eocc;
      logic        eir;
      int          edrop;
   } vec_t;

   vec_t tbl [17];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[DW-1:0];
   endfunction

   task automatic idle_all();
      m_if.in_valid = 0; m_if.in_data = '0; m_if.out_ready = 0; m_if.flush = 0; m_if.req = 0;
      s_if.in_valid = 0; s_if.in_data = '0; s_if.out_ready = 0; s_if.flush = 0; s_if.req = 0;
      n_if.in_valid = 0; n_if.in_data = '0; n_if.out_ready = 0; n_if.flush = 0; n_if.req = 0;
   endtask

   // Reference model state for the randomized phase.
   logic [DW-1:0] qm[$];
   logic [DW-1:0] qn[$];
   int            dm;
   int            dn;

   initial begin
      logic ir_m, ir_n, push, pop;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      idle_all();

      //            iv  d      or fl rq   ov  od     occ ir drop
      tbl[0]  = '{1, 32'h01, 1, 0, 0,  1, 32'h01, 1, 1, 0};
      tbl[1]  = '{1, 32'h02, 1, 0, 0,  1, 32'h02, 1, 1, 0};
      tbl[2]  = '{1, 32'h03, 1, 0, 0,  1, 32'h03, 1, 1, 0};
      tbl[3]  = '{0, 32'h00, 1, 0, 0,  0, 32'h00, 0, 1, 0};
      tbl[4]  = '{1, 32'h0A, 0, 0, 0,  1, 32'h0A, 1, 1, 0};
      tbl[5]  = '{1, 32'h0B, 0, 0, 0,  1, 32'h0A, 2, 0, 0};
      tbl[6]  = '{1, 32'h99, 1, 0, 0,  1, 32'h0B, 1, 1, 0};
      tbl[7]  = '{0, 32'h00, 1, 0, 0,  0, 32'h00, 0, 1, 0};
      tbl[8]  = '{1, 32'h11, 0, 0, 0,  1, 32'h11, 1, 1, 0};
      tbl[9]  = '{1, 32'h12, 0, 0, 0,  1, 32'h11, 2, 0, 0};
      tbl[10] = '{0, 32'h00, 0, 1, 0,  0, 32'h00, 0, 1, 2};
      tbl[11] = '{1, 32'h21, 0, 0, 0,  1, 32'h21, 1, 1, 2};
      tbl[12] = '{1, 32'h22, 0, 0, 0,  1, 32'h21, 2, 0, 2};
      tbl[13] = '{0, 32'h00, 0, 0, 1,  0, 32'h00, 0, 1, 4};
      tbl[14] = '{1, 32'h31, 0, 0, 0,  1, 32'h31, 1, 1, 4};
      tbl[15] = '{1, 32'h32, 1, 1, 0,  0, 32'h00, 0, 1, 5};
      tbl[16] = '{1, 32'h40, 0, 1, 0,  0, 32'h00, 0, 1, 6};

      // Reset state, observed while reset is held.
      #12;
      chk("rst_ov",   m_if.out_valid, 0);
      chk("rst_od",   m_if.out_data,  0);
      chk("rst_occ",  m_if.occupancy, 0);
      chk("rst_ir",   m_if.in_ready,  1);
      chk("rst_drop", m_if.drop_cnt,  0);
      chk("rst_ir_noskid", n_if.in_ready, 1);
      step();
      reset_n = 1'b1;
      step();
      chk("post_rst_occ", m_if.occupancy, 0);

      // Directed vector table on the default-configuration stage.
      for (int i = 0; i < 17; i++) begin
         m_if.in_valid  = tbl[i].iv;
         m_if.in_data   = DW'(tbl[i].d);
         m_if.out_ready = tbl[i].ordy;
         m_if.flush     = tbl[i].fl;
         m_if.req       = tbl[i].rq;
         step();
         chk($sformatf("vec%0d_ov", i),   m_if.out_valid, tbl[i].ev);
         chk($sformatf("vec%0d_od", i),   m_if.out_data,  DW'(tbl[i].ed));
         chk($sformatf("vec%0d_occ", i),  m_if.occupancy, tbl[i].eocc);
         chk($sformatf("vec%0d_ir", i),   m_if.in_ready,  tbl[i].eir);
         chk($sformatf("vec%0d_drop", i), m_if.drop_cnt,  DW'(tbl[i].edrop));
      end
      idle_all();

      // Saturation of a 2-bit counter: five single-entry flushes.
      for (int k = 0; k < 5; k++) begin
         s_if.in_valid = 1; s_if.in_data = DW'(k + 1); s_if.flush = 0;
         step();
         chk("sat_fill_occ", s_if.occupancy, 1);
         s_if.in_valid = 0; s_if.flush = 1;
         step();
         s_if.flush = 0;
         chk($sformatf("sat_drop%0d", k), s_if.drop_cnt, (k + 1 > 3) ? 3 : k + 1);
      end

      // Single-entry stage: ready follows out_ready combinationally.
      n_if.in_valid = 1; n_if.in_data = DW'(32'h5A); n_if.out_ready = 0;
      step();
      chk("ns_occ1", n_if.occupancy, 1);
      chk("ns_od1",  n_if.out_data,  DW'(32'h5A));
      n_if.in_data = DW'(32'h5B);
      #1;
      chk("ns_ir_stall", n_if.in_ready, 0);
      n_if.out_ready = 1;
      #1;
      chk("ns_ir_same_cycle", n_if.in_ready, 1);
      step();
      chk("ns_od2",  n_if.out_data,  DW'(32'h5B));
      chk("ns_ov2",  n_if.out_valid, 1);
      chk("ns_occ2", n_if.occupancy, 1);
      idle_all();
      step();

      // Asynchronous reset in the middle of a stall at occupancy 2.
      s_if.in_valid = 1; s_if.in_data = DW'(32'h77);
      step();
      s_if.in_data = DW'(32'h78);
      step();
      s_if.in_valid = 0;
      chk("ar_pre_occ", s_if.occupancy, 2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_ov",   s_if.out_valid, 0);
      chk("ar_od",   s_if.out_data,  0);
      chk("ar_drop", s_if.drop_cnt,  0);
      chk("ar_occ",  s_if.occupancy, 0);
      chk("ar_ir",   s_if.in_ready,  1);
      step();
      reset_n = 1'b1;
      step();
      chk("ar_after_occ", s_if.occupancy, 0);

      // Randomized traffic on both configurations against the queue model.
      dm = 0;
      dn = 0;
      for (int c = 0; c < 1500; c++) begin
         m_if.in_valid  = ($urandom_range(0, 3) != 0);
         m_if.in_data   = rnd_data();
         m_if.out_ready = ($urandom_range(0, 2) != 0);
         m_if.flush     = ($urandom_range(0, 15) == 0);
         m_if.req       = ($urandom_range(0, 19) == 0);
         n_if.in_valid  = ($urandom_range(0, 3) != 0);
         n_if.in_data   = rnd_data();
         n_if.out_ready = ($urandom_range(0, 2) != 0);
         n_if.flush     = ($urandom_range(0, 15) == 0);
         n_if.req       = ($urandom_range(0, 19) == 0);
         #1;
         ir_m = (qm.size() < 2);
         ir_n = (qn.size() == 0) || n_if.out_ready;
         chk("rnd_m_ir",   m_if.in_ready,  ir_m);
         chk("rnd_m_ov",   m_if.out_valid, qm.size() != 0);
         chk("rnd_m_od",   m_if.out_data,  (qm.size() != 0) ? qm[0] : '0);
         chk("rnd_m_occ",  m_if.occupancy, DW'(qm.size()));
         chk("rnd_m_drop", m_if.drop_cnt,  DW'(dm));
         chk("rnd_n_ir",   n_if.in_ready,  ir_n);
         chk("rnd_n_ov",   n_if.out_valid, qn.size() != 0);
         chk("rnd_n_od",   n_if.out_data,  (qn.size() != 0) ? qn[0] : '0);
         chk("rnd_n_occ",  n_if.occupancy, DW'(qn.size()));
         chk("rnd_n_drop", n_if.drop_cnt,  DW'(dn));

         push = m_if.in_valid && ir_m;
         pop  = (qm.size() != 0) && m_if.out_ready;
         if (m_if.flush || m_if.req) begin
            dm = dm + qm.size() - int'(pop) + int'(push);
            if (dm > 65535) dm = 65535;
            qm.delete();
         end else begin
            if (pop)  void'(qm.pop_front());
            if (push) qm.push_back(m_if.in_data);
         end

         push = n_if.in_valid && ir_n;
         pop  = (qn.size() != 0) && n_if.out_ready;
         if (n_if.flush || n_if.req) begin
            dn = dn + qn.size() - int'(pop) + int'(push);
            if (dn > 65535) dn = 65535;
            qn.delete();
         end else begin
            if (pop)  void'(qn.pop_front());
            if (push) qn.push_back(n_if.in_data);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
